// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus: registered request/address out, one-cycle ack strobe with data back.
interface instr_sequencer_if #(
  parameter int PC_W   = 5,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit core: owns the PC and IR,
// sequences ALU / register-file enables and traps halt opcodes and fetch timeouts.
module instr_sequencer #(
  parameter int         PC_W    = 5,
  parameter int         INST_W  = 32,
  parameter logic [7:0] HALT_OP = 8'hFF,
  parameter int         TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  instr_sequencer_if.master imem,
  output logic [INST_W-1:0] ir,
  input  logic              dec_w_r,
  input  logic              dec_rst,
  input  logic              dec_pc_inc,
  input  logic              dec_jmp,
  input  logic [PC_W-1:0]   dec_jmp_add,
  output logic              alu_en,
  output logic              rf_we,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic [7:0]        retired,
  output logic              halted,
  output logic              fault
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;
  localparam logic [2:0] FAULT  = 3'd6;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic            w_r;
    logic            rst;
    logic            pc_inc;
    logic            jmp;
    logic [PC_W-1:0] jmp_add;
  } ctl_t;

  ctl_t       ctl;
  logic [7:0] tcnt;
  logic       req;

  // pc is itself a register, so the address stays registered and stable through FETCH
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
      req     <= 1'b0;
      alu_en  <= 1'b0;
      rf_we   <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
      ctl     <= '0;
      tcnt    <= '0;
    end else begin
      alu_en <= 1'b0;
      rf_we  <= 1'b0;
      case (state)
        IDLE: if (run) begin
          state <= FETCH;
          req   <= 1'b1;
          tcnt  <= '0;
        end
        FETCH: begin
          // ack on the final allowed cycle still completes the fetch
          if (imem.imem_ack) begin
            ir    <= imem.imem_rdata;
            req   <= 1'b0;
            state <= DECODE;
          end else if (tcnt == TO_LAST) begin
            req   <= 1'b0;
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DECODE: begin
          if (ir[INST_W-1 -: 8] == HALT_OP) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            ctl    <= '{w_r: dec_w_r, rst: dec_rst, pc_inc: dec_pc_inc,
                        jmp: dec_jmp, jmp_add: dec_jmp_add};
            alu_en <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (ctl.rst) begin
            pc      <= '0;
            retired <= sat_inc(retired);
            state   <= IDLE;
          end else begin
            rf_we <= ctl.w_r;
            state <= WB;
          end
        end
        WB: begin
          if (ctl.jmp)         pc <= ctl.jmp_add;
          else if (ctl.pc_inc) pc <= pc + 1'b1;
          retired <= sat_inc(retired);
          if (run) begin
            state <= FETCH;
            req   <= 1'b1;
            tcnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        HALT, FAULT: ;
        default: begin
          state  <= IDLE;
          req    <= 1'b0;
          halted <= 1'b0;
          fault  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fetch/decode/exec/wb flow, jumps, wrap, halt, hold, saturation, timeout.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] ir;
  logic        dec_w_r = 1'b0, dec_rst = 1'b0, dec_pc_inc = 1'b0, dec_jmp = 1'b0;
  logic [4:0]  dec_jmp_add = '0;
  logic        alu_en, rf_we, halted, fault;
  logic [4:0]  pc;
  logic [2:0]  state;
  logic [7:0]  retired;
  int          nvec = 0;
  int          nerr = 0;

  instr_sequencer_if #(.PC_W(5), .INST_W(32)) imem_bus ();

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem(imem_bus.master), .ir(ir),
    .dec_w_r(dec_w_r), .dec_rst(dec_rst), .dec_pc_inc(dec_pc_inc),
    .dec_jmp(dec_jmp), .dec_jmp_add(dec_jmp_add),
    .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .state(state),
    .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic wr, input logic rs, input logic inc,
                         input logic jp, input logic [4:0] ja);
    dec_w_r = wr; dec_rst = rs; dec_pc_inc = inc; dec_jmp = jp; dec_jmp_add = ja;
  endtask

  // ack on the current FETCH cycle, then step through DECODE, EXEC, WB
  task automatic do_instr(input logic [31:0] word);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = word;
    tick();
    imem_bus.imem_ack = 1'b0;
    tick(3);
  endtask

  initial begin
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    #2;
    chk("rst_state",   32'(state), 32'd0);
    chk("rst_pc",      32'(pc), 32'd0);
    chk("rst_ir",      ir, 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_req",     32'(imem_bus.imem_req), 32'd0);
    chk("rst_flags",   {alu_en, rf_we, halted, fault}, 32'd0);
    #5 rst_n = 1'b1;

    // load-immediate at pc=0, ack after two wait cycles
    set_dec(1, 0, 1, 0, 5'd0);
    run = 1'b1;
    tick();
    chk("li_fetch_state", 32'(state), 32'd1);
    chk("li_req",         32'(imem_bus.imem_req), 32'd1);
    chk("li_addr",        32'(imem_bus.imem_addr), 32'd0);
    tick(2);
    chk("li_wait_state",  32'(state), 32'd1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h07050a01;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk("li_decode",      32'(state), 32'd2);
    chk("li_ir",          ir, 32'h07050a01);
    chk("li_req_drop",    32'(imem_bus.imem_req), 32'd0);
    tick();
    chk("li_exec_alu",    {state, alu_en, rf_we}, {3'd3, 1'b1, 1'b0});
    tick();
    chk("li_wb_rfwe",     {state, alu_en, rf_we}, {3'd4, 1'b0, 1'b1});
    tick();
    chk("li_done",        {state, pc, retired, rf_we}, {3'd1, 5'd1, 8'd1, 1'b0});
    chk("li_addr1",       32'(imem_bus.imem_addr), 32'd1);

    // asynchronous reset mid-FETCH
    #3 rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(imem_bus.imem_req), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_pc",    32'(pc), 32'd0);
    chk("arst_cnt",   {ir, retired}, 40'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_refetch", {state, pc}, {3'd1, 5'd0});

    // jump to 12 while run drops during EXEC
    set_dec(0, 0, 1, 1, 5'd12);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h01000000;
    tick();
    imem_bus.imem_ack = 1'b0;
    tick();
    chk("jmp_exec", {state, alu_en}, {3'd3, 1'b1});
    run = 1'b0;
    tick();
    chk("jmp_wb_norfwe", {state, rf_we}, {3'd4, 1'b0});
    tick();
    chk("jmp_idle", {state, pc, retired}, {3'd0, 5'd12, 8'd1});
    tick(2);
    chk("idle_stays", {state, imem_bus.imem_req}, {3'd0, 1'b0});

    // jump to 31, then pc_inc wraps to 0
    run = 1'b1;
    set_dec(0, 0, 0, 1, 5'd31);
    tick();
    chk("j31_addr", 32'(imem_bus.imem_addr), 32'd12);
    do_instr(32'h02000000);
    chk("j31_pc", {state, pc, retired}, {3'd1, 5'd31, 8'd2});
    set_dec(1, 0, 1, 0, 5'd3);
    do_instr(32'h03000000);
    chk("wrap_pc", {state, pc, retired}, {3'd1, 5'd0, 8'd3});

    // halt opcode: sticky, no retire, ir frozen against stray acks
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hFF000000;
    tick();
    imem_bus.imem_ack = 1'b0;
    tick();
    chk("halt_state", {state, halted, fault}, {3'd5, 1'b1, 1'b0});
    chk("halt_retired", {pc, retired}, {5'd0, 8'd3});
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h12345678;
    tick(3);
    imem_bus.imem_ack = 1'b0;
    chk("halt_sticky", {state, imem_bus.imem_req, alu_en, rf_we}, {3'd5, 1'b0, 1'b0, 1'b0});
    chk("halt_ir", ir, 32'hFF000000);

    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    chk("halt_cleared", {state, halted}, {3'd0, 1'b0});

    // hold: same address re-fetched; 300 retirements saturate at 255
    set_dec(0, 0, 0, 0, 5'd9);
    tick();
    do_instr(32'h04000000);
    chk("hold_pc", {state, pc, imem_bus.imem_addr, retired}, {3'd1, 5'd0, 5'd0, 8'd1});
    for (int i = 1; i < 300; i++) do_instr(32'h04000000);
    chk("sat_retired", 32'(retired), 32'd255);

    // ack on exactly the TIMEOUT-th cycle still decodes; decoder reset returns to IDLE
    set_dec(1, 1, 1, 1, 5'd20);
    tick(7);
    chk("to7_still_fetch", 32'(state), 32'd1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h05000000;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk("to8_ack_decode", {state, fault}, {3'd2, 1'b0});
    tick();
    chk("drst_exec", {state, alu_en}, {3'd3, 1'b1});
    tick();
    chk("drst_idle", {state, pc, retired, rf_we}, {3'd0, 5'd0, 8'd255, 1'b0});

    // timeout: no ack for the full window
    set_dec(0, 0, 1, 0, 5'd0);
    tick();
    chk("to_fetch", 32'(state), 32'd1);
    tick(7);
    chk("to_pre", {state, fault}, {3'd1, 1'b0});
    tick();
    chk("to_fault", {state, fault, imem_bus.imem_req}, {3'd6, 1'b1, 1'b0});
    tick(4);
    chk("to_sticky", {state, fault, halted}, {3'd6, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
